// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), one byte per transfer, MSB first.
// Transfer timeline, with cycle 0 being the PCLK edge that accepts START:
//   cycle 1                 : SS low, MOSI = bit 7, BUSY high
//   cycle 1 + CLK_DIV       : first SCK rising edge
//   cycle 1 + 16*CLK_DIV    : 8th SCK falling edge, MOSI returns to 0
//   cycle 1 + 17*CLK_DIV    : SS high, RX_DATA updated
//   cycle 1 + 18*CLK_DIV    : DONE pulse, BUSY low, back to IDLE
// All outputs come straight from flops, so SCK/MOSI/SS are glitch free.
module spi_master #(
    parameter int unsigned CLK_DIV = 4  // SCK half-period in PCLK cycles, 1..255
) (
    input  logic       i_pclk,
    input  logic       i_presetn,
    input  logic       i_start,
    input  logic [7:0] i_tx_data,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_ss,
    output logic [7:0] o_rx_data,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [7:0] DivLast = 8'(CLK_DIV);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StXfer  = 3'd2,
        StHold  = 3'd3,
        StGap   = 3'd4
    } state_t;

    // Registered state
    state_t     r_state;
    logic [7:0] r_div_cnt;   // cycles spent in the current SCK phase / state
    logic [3:0] r_bit_cnt;   // SCK falling edges seen so far
    logic [7:0] r_shift;     // TX bits still to send; received bits enter at the LSB
    logic       r_miso_bit;  // MISO captured on the latest SCK rising edge
    logic       r_sck;
    logic       r_mosi;
    logic       r_ss;
    logic [7:0] r_rx;
    logic       r_busy;
    logic       r_done;

    // Next-state values
    state_t     w_state_nxt;
    logic [7:0] w_div_cnt_nxt;
    logic [3:0] w_bit_cnt_nxt;
    logic [7:0] w_shift_nxt;
    logic       w_miso_bit_nxt;
    logic       w_sck_nxt;
    logic       w_mosi_nxt;
    logic       w_ss_nxt;
    logic [7:0] w_rx_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;

    logic       w_div_end;
    logic       w_last_fall;

    // The current phase has run its full CLK_DIV cycles.
    assign w_div_end   = (r_div_cnt == DivLast);
    // The SCK falling edge about to be generated is the 8th one.
    assign w_last_fall = (r_bit_cnt == 4'd7);

    // State and output registers; reset forces the idle bus immediately.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state    <= StIdle;
            r_div_cnt  <= 8'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_miso_bit <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss       <= 1'b1;
            r_rx       <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_miso_bit <= w_miso_bit_nxt;
            r_sck      <= w_sck_nxt;
            r_mosi     <= w_mosi_nxt;
            r_ss       <= w_ss_nxt;
            r_rx       <= w_rx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and next-output decode for the transfer sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_cnt_nxt  = r_div_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_miso_bit_nxt = r_miso_bit;
        w_sck_nxt      = r_sck;
        w_mosi_nxt     = r_mosi;
        w_ss_nxt       = r_ss;
        w_rx_nxt       = r_rx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        unique case (r_state)
            StIdle: begin
                // Bus outputs are already idle here; only a new request matters.
                if (i_start) begin
                    w_state_nxt   = StSetup;
                    w_shift_nxt   = i_tx_data;
                    w_div_cnt_nxt = 8'd0;
                    w_bit_cnt_nxt = 4'd0;
                    w_busy_nxt    = 1'b1;
                end
            end

            StSetup: begin
                // Counter starts at 0 on the accept edge, so SS falls one cycle
                // later and SCK rises CLK_DIV cycles after that.
                w_ss_nxt   = 1'b0;
                w_mosi_nxt = r_shift[7];
                if (w_div_end) begin
                    w_state_nxt    = StXfer;
                    w_sck_nxt      = 1'b1;
                    w_miso_bit_nxt = i_miso;
                    w_div_cnt_nxt  = 8'd1;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end

            StXfer: begin
                if (w_div_end) begin
                    w_div_cnt_nxt = 8'd1;
                    if (r_sck) begin
                        // Falling edge: advance to the next bit unless this is the 8th.
                        w_sck_nxt     = 1'b0;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (w_last_fall) begin
                            w_mosi_nxt  = 1'b0;
                            w_state_nxt = StHold;
                        end else begin
                            // The bit captured on the preceding rise enters at the
                            // LSB here, so TX bit 0 is not overwritten before it
                            // has been driven.
                            w_shift_nxt = {r_shift[6:0], r_miso_bit};
                            w_mosi_nxt  = r_shift[6];
                        end
                    end else begin
                        // Rising edge: slave data has been stable for a half period.
                        w_sck_nxt      = 1'b1;
                        w_miso_bit_nxt = i_miso;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end

            StHold: begin
                if (w_div_end) begin
                    // Seven bits sit in the shift register, the 8th is still
                    // in the capture flop.
                    w_state_nxt   = StGap;
                    w_ss_nxt      = 1'b1;
                    w_rx_nxt      = {r_shift[6:0], r_miso_bit};
                    w_div_cnt_nxt = 8'd1;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end

            StGap: begin
                // SS stays high for CLK_DIV cycles before a new START can be taken.
                if (w_div_end) begin
                    w_state_nxt   = StIdle;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_div_cnt_nxt = 8'd0;
                    w_bit_cnt_nxt = 4'd0;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_sck     = r_sck;
    assign o_mosi    = r_mosi;
    assign o_ss      = r_ss;
    assign o_rx_data = r_rx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

`ifndef SYNTHESIS
    // DONE is a single-cycle pulse.
    a_done_pulse : assert property (@(posedge i_pclk) disable iff (!i_presetn)
        r_done |=> !r_done);
    // DONE only appears once the block has gone idle.
    a_done_idle : assert property (@(posedge i_pclk) disable iff (!i_presetn)
        r_done |-> (!r_busy && r_ss));
    // The slave is only selected during a busy transfer.
    a_ss_busy : assert property (@(posedge i_pclk) disable iff (!i_presetn)
        !r_ss |-> r_busy);
    // SCK never toggles while the slave is deselected.
    a_sck_ss : assert property (@(posedge i_pclk) disable iff (!i_presetn)
        r_sck |-> !r_ss);
    // The bit counter never passes 8 within a transfer.
    a_bit_cnt : assert property (@(posedge i_pclk) disable iff (!i_presetn)
        r_bit_cnt <= 4'd8);
`endif

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four instances with CLK_DIV = 1..4, each with a mode-0
// slave model. Expected RX bytes go into a scoreboard queue when a transfer is
// launched and are popped when that instance pulses DONE.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]      rst_n;
    logic [3:0]      start;
    logic [3:0]      miso;
    logic [3:0]      sck;
    logic [3:0]      mosi;
    logic [3:0]      ss;
    logic [3:0]      busy;
    logic [3:0]      done;
    logic [3:0]      loopb;
    logic [3:0][7:0] tx;
    logic [3:0][7:0] rx;
    logic [3:0][7:0] sl_data;
    logic [3:0][7:0] prev_rx;

    logic [7:0] sb_q[$];
    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < 4; g++) begin : g_inst
        logic [3:0] sl_nfall = 4'd0;
        logic [7:0] sl_in = 8'd0;

        spi_master #(.CLK_DIV(g + 1)) u_dut (
            .i_pclk    (clk),
            .i_presetn (rst_n[g]),
            .i_start   (start[g]),
            .i_tx_data (tx[g]),
            .i_miso    (miso[g]),
            .o_sck     (sck[g]),
            .o_mosi    (mosi[g]),
            .o_ss      (ss[g]),
            .o_rx_data (rx[g]),
            .o_busy    (busy[g]),
            .o_done    (done[g])
        );

        // Mode-0 slave: presents bit 7 as soon as SS falls, next bit after each fall.
        always @(negedge sck[g] or posedge ss[g]) begin
            if (ss[g]) sl_nfall <= 4'd0;
            else       sl_nfall <= sl_nfall + 4'd1;
        end
        always @(posedge sck[g]) begin
            if (!ss[g]) sl_in <= {sl_in[6:0], mosi[g]};
        end
        assign miso[g] = loopb[g] ? mosi[g] : sl_data[g][3'd7 - sl_nfall[2:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One transfer on instance i. Entered and left right after a falling clock edge.
    // hold: leave START high; poke: cycle at which a stray START/TX_DATA=FF is driven;
    // rst_cyc: cycle at which reset is asserted mid-transfer (-1 = never).
    task automatic run_xfer(input int i, input logic [7:0] tx_b, input logic [7:0] sl_b,
                            input bit lb, input bit hold, input int poke, input int rst_cyc);
        int         d = i + 1;
        int         last = 1 + 18 * d;
        logic [7:0] expv = lb ? tx_b : sl_b;
        logic [7:0] bits = 8'd0;
        logic [7:0] got;
        int         rises = 0;
        int         first_low = -1;
        int         last_low = -1;
        int         ndone = 0;
        int         done_c = -1;
        logic       prev_sck = 1'b0;

        start[i]   = 1'b1;
        tx[i]      = tx_b;
        sl_data[i] = sl_b;
        loopb[i]   = lb;
        sb_q.push_back(expv);

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_eq($sformatf("d%0d_c0_ss", d), ss[i], 1'b1);
                check_eq($sformatf("d%0d_c0_done", d), done[i], 1'b0);
                if (!hold) start[i] = 1'b0;
                tx[i] = ~tx_b;
            end
            if (c == 1) begin
                check_eq($sformatf("d%0d_c1_ss", d), ss[i], 1'b0);
                check_eq($sformatf("d%0d_c1_busy", d), busy[i], 1'b1);
                check_eq($sformatf("d%0d_c1_mosi", d), mosi[i], tx_b[7]);
                check_eq($sformatf("d%0d_c1_sck", d), sck[i], 1'b0);
            end
            if (poke >= 0 && c == poke) begin
                start[i] = 1'b1;
                tx[i]    = 8'hFF;
            end
            if (poke >= 0 && c == poke + 1) start[i] = 1'b0;
            if (sck[i] && !prev_sck && !ss[i]) begin
                rises++;
                bits = {bits[6:0], mosi[i]};
            end
            prev_sck = sck[i];
            if (!ss[i]) begin
                if (first_low < 0) first_low = c;
                last_low = c;
            end
            if (done[i]) begin
                ndone++;
                if (done_c < 0) begin
                    done_c = c;
                    check_eq($sformatf("d%0d_done_busy", d), busy[i], 1'b0);
                    if (sb_q.size() > 0) begin
                        got = sb_q.pop_front();
                        check_eq($sformatf("d%0d_rx_sb", d), rx[i], got);
                    end
                end
            end
            if (c == 17 * d)
                check_eq($sformatf("d%0d_rx_held", d), rx[i], prev_rx[i]);
            if (c == 1 + 16 * d) begin
                check_eq($sformatf("d%0d_end_mosi", d), mosi[i], 1'b0);
                check_eq($sformatf("d%0d_end_sck", d), sck[i], 1'b0);
            end
            if (c == 1 + 17 * d) begin
                check_eq($sformatf("d%0d_ss_rise", d), ss[i], 1'b1);
                check_eq($sformatf("d%0d_rx_load", d), rx[i], expv);
            end
            if (c == rst_cyc) begin
                rst_n[i] = 1'b0;
                #1;
                check_eq($sformatf("d%0d_rst_ss", d), ss[i], 1'b1);
                check_eq($sformatf("d%0d_rst_sck", d), sck[i], 1'b0);
                check_eq($sformatf("d%0d_rst_busy", d), busy[i], 1'b0);
                check_eq($sformatf("d%0d_rst_rx", d), rx[i], 8'h00);
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_eq($sformatf("d%0d_rst_nodone", d), done[i], 1'b0);
                end
                rst_n[i]   = 1'b1;
                start[i]   = 1'b0;
                prev_rx[i] = 8'h00;
                @(negedge clk);
                return;
            end
        end

        check_eq($sformatf("d%0d_ndone", d), ndone, 1);
        check_eq($sformatf("d%0d_done_cyc", d), done_c, last);
        check_eq($sformatf("d%0d_ss_first", d), first_low, 1);
        check_eq($sformatf("d%0d_ss_last", d), last_low, 17 * d);
        check_eq($sformatf("d%0d_rises", d), rises, 8);
        check_eq($sformatf("d%0d_mosi_bits", d), bits, tx_b);
        if (done_c < 0 && sb_q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL d%0d_sb_nodone: got no DONE expected rx %0h", d, sb_q.pop_front());
        end
        prev_rx[i] = expv;
    endtask

    initial begin
        rst_n   = '0;
        start   = '0;
        tx      = '0;
        sl_data = '0;
        loopb   = '0;
        prev_rx = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rst%0d_sck", i), sck[i], 1'b0);
            check_eq($sformatf("rst%0d_mosi", i), mosi[i], 1'b0);
            check_eq($sformatf("rst%0d_ss", i), ss[i], 1'b1);
            check_eq($sformatf("rst%0d_busy", i), busy[i], 1'b0);
            check_eq($sformatf("rst%0d_done", i), done[i], 1'b0);
            check_eq($sformatf("rst%0d_rx", i), rx[i], 8'h00);
        end
        rst_n = '1;
        @(negedge clk);

        // CLK_DIV=2 reference transfer.
        run_xfer(1, 8'hA5, 8'h3C, 1'b0, 1'b0, -1, -1);
        // CLK_DIV=1 back-to-back with START held high.
        run_xfer(0, 8'h96, 8'h69, 1'b0, 1'b1, -1, -1);
        run_xfer(0, 8'h3E, 8'hE3, 1'b0, 1'b0, -1, -1);
        // CLK_DIV=4 with a stray START and TX_DATA change at cycle 10.
        run_xfer(3, 8'h5C, 8'hA7, 1'b0, 1'b0, 10, -1);
        // CLK_DIV=2 reset at cycle 20, then a normal transfer against the slave.
        run_xfer(1, 8'h77, 8'h11, 1'b0, 1'b0, -1, 20);
        run_xfer(1, 8'hC3, 8'h5A, 1'b0, 1'b0, -1, -1);
        check_eq("slave_out", g_inst[1].sl_in, 8'hC3);
        // CLK_DIV=3 loopback.
        run_xfer(2, 8'h81, 8'h00, 1'b1, 1'b0, -1, -1);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
